// File: rtl/riscv_core_ahb_pkg.sv
// rtl/riscv_core_ahb_pkg.sv - shared AHB-Lite encodings, data-memory states and byte-lane helpers
package riscv_core_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } dmem_state_e;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

  // Little-endian byte strobe; offset bits below the size alignment are ignored.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      HSIZE_BYTE: return 4'b0001 << offset;
      HSIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_dmem_array.sv
// rtl/riscv_core_dmem_array.sv - word array with byte-lane synchronous write and combinational read
module riscv_core_dmem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_strb,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Update only the strobed byte lanes; contents are never reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_strb[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/riscv_core_ahb_dmem_slave.sv
// rtl/riscv_core_ahb_dmem_slave.sv - AHB-Lite data memory responder; error responses under RISCV_CORE_AHB_DMEM_ERR_EN
module riscv_core_ahb_dmem_slave
  import riscv_core_ahb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ldst_HSEL,
  input  logic [31:0] ldst_HADDR,
  input  logic [1:0]  ldst_HTRANS,
  input  logic        ldst_HWRITE,
  input  logic [2:0]  ldst_HSIZE,
  input  logic [2:0]  ldst_HBURST,
  input  logic [3:0]  ldst_HPROT,
  input  logic        ldst_HMASTLOCK,
  input  logic [31:0] ldst_HWDATA,
  input  logic        ldst_HREADY,
  output logic [31:0] ldst_HRDATA,
  output logic        ldst_HREADYOUT,
  output logic        ldst_HRESP
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS          = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS) << 2;

  dmem_state_e   r_state, w_state_nxt, w_entry_state;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_index;
  logic [1:0]    r_offset;
  logic [2:0]    r_size;
  logic          r_write;
  logic [31:0]   w_rel_addr;
  logic [31:0]   w_rdata;
  logic [2:0]    w_size;
  logic [3:0]    w_strb;
  logic          w_hreadyout;
  logic          w_accept;
  logic          w_unused_ok;

  // BASE_ADDR is aligned to the array size, so the low bits of the relative
  // address are the in-array word index and byte offset.
  assign w_rel_addr  = ldst_HADDR - BASE_ADDR;
  assign w_size      = (ldst_HSIZE > HSIZE_WORD) ? HSIZE_WORD : ldst_HSIZE;
  assign w_hreadyout = (r_state != ST_WAIT) && (r_state != ST_ERR1);
  assign w_accept    = ldst_HSEL && ldst_HREADY && htrans_active(ldst_HTRANS) && w_hreadyout;
  assign w_unused_ok = ^{ldst_HBURST, ldst_HPROT, ldst_HMASTLOCK, w_rel_addr[31:AW+2]};

`ifdef RISCV_CORE_AHB_DMEM_ERR_EN
  logic w_illegal;
  assign w_illegal = (w_rel_addr >= DEPTH_BYTES) ||
                     (ldst_HSIZE > HSIZE_WORD) ||
                     ((ldst_HSIZE == HSIZE_HALF) && w_rel_addr[0]) ||
                     ((ldst_HSIZE == HSIZE_WORD) && (w_rel_addr[1:0] != 2'b00));
  assign w_entry_state = w_illegal ? ST_ERR1 : ((WS != 4'd0) ? ST_WAIT : ST_DATA);
  assign ldst_HRESP    = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign w_entry_state = (WS != 4'd0) ? ST_WAIT : ST_DATA;
  assign ldst_HRESP    = HRESP_OKAY;
`endif

  // State and wait-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the address phase for use in the following data phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_index  <= '0;
      r_offset <= 2'b00;
      r_size   <= HSIZE_BYTE;
      r_write  <= 1'b0;
    end else if (w_accept) begin
      r_index  <= w_rel_addr[AW+1:2];
      r_offset <= w_rel_addr[1:0];
      r_size   <= w_size;
      r_write  <= ldst_HWRITE;
    end
  end

  // Next state: waits count down to DATA, ERR1 always moves to ERR2, and every
  // ready state either re-enters on a pipelined phase or falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef RISCV_CORE_AHB_DMEM_ERR_EN
      ST_ERR1: w_state_nxt = ST_ERR2;
`endif
      default: begin
        if (w_accept) begin
          w_state_nxt = w_entry_state;
          w_cnt_nxt   = WS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // A reset landing on the last data cycle cancels the commit.
  assign w_strb = ((r_state == ST_DATA) && r_write && !RST) ? lane_mask(r_size, r_offset) : 4'b0000;

  riscv_core_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (CLK),
    .i_addr  (r_index),
    .i_strb  (w_strb),
    .i_wdata (ldst_HWDATA),
    .o_rdata (w_rdata)
  );

  assign ldst_HREADYOUT = w_hreadyout;
  assign ldst_HRDATA    = (r_state == ST_DATA) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_riscv_core_ahb_dmem_slave.sv
// tb/tb_riscv_core_ahb_dmem_slave.sv - randomized bench for the data memory responder against a byte-level model
module tb_riscv_core_ahb_dmem_slave;

  localparam int          DEPTH  = 64;
  localparam int          NBYTES = DEPTH * 4;
  localparam logic [31:0] BASE   = 32'h0001_0000;
`ifdef RISCV_CORE_AHB_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  logic [7:0]  mb [2][NBYTES];
  logic [31:0] last_rd [2];
  tx_t         q[$];
  int          n_cmp;
  int          n_err;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_core_ahb_dmem_slave #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_STATES ((g == 0) ? 0 : 3)
    ) u_dut (
      .CLK            (clk),
      .RST            (rst[g]),
      .ldst_HSEL      (hsel[g]),
      .ldst_HADDR     (haddr[g]),
      .ldst_HTRANS    (htrans[g]),
      .ldst_HWRITE    (hwrite[g]),
      .ldst_HSIZE     (hsize[g]),
      .ldst_HBURST    (3'b000),
      .ldst_HPROT     (4'b0011),
      .ldst_HMASTLOCK (1'b0),
      .ldst_HWDATA    (hwdata[g]),
      .ldst_HREADY    (hreadyout[g]),
      .ldst_HRDATA    (hrdata[g]),
      .ldst_HREADYOUT (hreadyout[g]),
      .ldst_HRESP     (hresp[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes_of(input logic [2:0] sz);
    return (sz == 3'd0) ? 1 : ((sz == 3'd1) ? 2 : 4);
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] off;
    off = a - BASE;
    if (!ERR_EN) return 1'b0;
    if (off >= 32'(NBYTES)) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    if ((sz == 3'd1) && (a % 2 != 0)) return 1'b1;
    if ((sz == 3'd2) && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int byte_off(input logic [31:0] a);
    return int'((a - BASE) % 32'(NBYTES));
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n;
    int st;
    int p;
    n  = nbytes_of(sz);
    st = byte_off(a) - (byte_off(a) % n);
    for (int i = 0; i < n; i++) begin
      p = st + i;
      mb[k][p] = d[8*(p%4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
    int w;
    w = byte_off(a) - (byte_off(a) % 4);
    return {mb[k][w+3], mb[k][w+2], mb[k][w+1], mb[k][w]};
  endfunction

  function automatic tx_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d, input int gap);
    tx_t t;
    t.wr = wr; t.addr = a; t.size = sz; t.wdata = d; t.gap = gap;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    int  r;
    r       = $urandom_range(0, 15);
    t.wr    = 1'($urandom_range(0, 1));
    t.addr  = (r == 0) ? $urandom : BASE + 32'($urandom_range(0, NBYTES - 1));
    t.size  = (r == 1) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.wdata = $urandom;
    t.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    return t;
  endfunction

  task automatic drive_slot(input int k, input bit valid, input tx_t t);
    if (valid) begin
      hsel[k]   = 1'b1;
      haddr[k]  = t.addr;
      htrans[k] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      hwrite[k] = t.wr;
      hsize[k]  = t.size;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin hsel[k] = 1'b1; htrans[k] = 2'b00; end
        1:       begin hsel[k] = 1'b1; htrans[k] = 2'b01; end
        default: begin hsel[k] = 1'b0; htrans[k] = 2'b10; end
      endcase
      haddr[k]  = $urandom;
      hwrite[k] = 1'($urandom_range(0, 1));
      hsize[k]  = 3'($urandom_range(0, 2));
    end
  endtask

  // Pipelined master: the address phase advances only on cycles the slave is ready.
  task automatic run_q(input int k);
    int  ti;
    int  gap;
    int  waits;
    int  cyc;
    bit  avalid;
    bit  pend;
    bit  rdy;
    bit  exp_err;
    tx_t at;
    tx_t pt;
    ti = 0; waits = 0; cyc = 0; avalid = 1'b0; pend = 1'b0; rdy = 1'b1;
    gap = (q.size() > 0) ? q[0].gap : 0;
    at = mk(1'b0, 32'd0, 3'd0, 32'd0, 0);
    pt = at;
    @(posedge clk); #1;
    forever begin
      if (rdy) begin
        pend  = avalid;
        pt    = at;
        waits = 0;
        hwdata[k] = (avalid && at.wr) ? at.wdata : $urandom;
        if (!pend && (ti >= q.size())) break;
        if ((ti < q.size()) && (gap == 0)) begin
          at     = q[ti];
          avalid = 1'b1;
          ti++;
          gap = (ti < q.size()) ? q[ti].gap : 0;
        end else begin
          avalid = 1'b0;
          if (gap > 0) gap--;
        end
        drive_slot(k, avalid, at);
      end
      @(negedge clk);
      cyc++;
      if ((cyc > 4000) || (waits > 20)) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout: inst %0d stalled at tx %0d (waits %0d)", k, ti, waits);
        break;
      end
      rdy = hreadyout[k];
      if (pend) begin
        exp_err = is_illegal(pt.addr, pt.size);
        if (!rdy) begin
          waits++;
          check_eq("hresp_stall", 32'(hresp[k]), 32'(exp_err));
        end else begin
          check_eq("wait_count", waits, exp_err ? 1 : ws_of(k));
          check_eq("hresp_done", 32'(hresp[k]), 32'(exp_err));
          if (!pt.wr) begin
            check_eq("rdata", hrdata[k], exp_err ? 32'd0 : model_read(k, pt.addr));
            last_rd[k] = hrdata[k];
          end else if (!exp_err) begin
            model_write(k, pt.addr, pt.size, pt.wdata);
          end
        end
      end else begin
        check_eq("idle_ready", 32'(hreadyout[k]), 32'd1);
        check_eq("idle_resp", 32'(hresp[k]), 32'd0);
        check_eq("idle_rdata", hrdata[k], 32'd0);
      end
      @(posedge clk); #1;
    end
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
  endtask

  // Reset lands while a write to 0x0001_0040 is still in its data phase.
  task automatic rst_abort(input int k);
    logic [31:0] old;
    old = model_read(k, 32'h0001_0040);
    @(posedge clk); #1;
    hsel[k] = 1'b1; haddr[k] = 32'h0001_0040; htrans[k] = 2'b10; hwrite[k] = 1'b1; hsize[k] = 3'd2;
    @(posedge clk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwdata[k] = ~old; rst[k] = 1'b1;
    @(negedge clk);
    check_eq("abort_stall", 32'(hreadyout[k]), (ws_of(k) == 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    rst[k] = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", 32'(hreadyout[k]), 32'd1);
    check_eq("abort_resp", 32'(hresp[k]), 32'd0);
    check_eq("abort_rdata", hrdata[k], 32'd0);
    q.delete();
    q.push_back(mk(1'b0, 32'h0001_0040, 3'd2, 32'd0, 0));
    run_q(k);
    check_eq("abort_old", last_rd[k], old);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; hsel[k] = 1'b0; haddr[k] = 32'd0; htrans[k] = 2'b00;
      hwrite[k] = 1'b0; hsize[k] = 3'd0; hwdata[k] = 32'd0; last_rd[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ready", 32'(hreadyout[k]), 32'd1);
      check_eq("rst_resp", 32'(hresp[k]), 32'd0);
      check_eq("rst_rdata", hrdata[k], 32'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      q.delete();
      for (int w = 0; w < DEPTH; w++) q.push_back(mk(1'b1, BASE + 32'(4 * w), 3'd2, $urandom, 0));
      run_q(k);

      q.delete();
      q.push_back(mk(1'b1, 32'h0001_0010, 3'd2, 32'hDEAD_BEEF, 0));
      q.push_back(mk(1'b0, 32'h0001_0010, 3'd2, 32'd0, 0));
      run_q(k);
      check_eq("plan_word", last_rd[k], 32'hDEAD_BEEF);

      q.delete();
      q.push_back(mk(1'b1, 32'h0001_0012, 3'd0, 32'h00AB_0000, 1));
      q.push_back(mk(1'b0, 32'h0001_0010, 3'd2, 32'd0, 0));
      run_q(k);
      check_eq("plan_byte", last_rd[k], 32'hDEAB_BEEF);

      q.delete();
      q.push_back(mk(1'b1, 32'h0001_0022, 3'd1, 32'h1234_0000, 0));
      q.push_back(mk(1'b0, 32'h0001_0020, 3'd2, 32'd0, 0));
      run_q(k);
      check_eq("plan_half", 32'(last_rd[k][31:16]), 32'h0000_1234);

      q.delete();
      q.push_back(mk(1'b0, 32'h0000_0000, 3'd2, 32'd0, 0));
      q.push_back(mk(1'b1, 32'h0001_0001, 3'd1, 32'h5A5A_5A5A, 0));
      q.push_back(mk(1'b0, 32'h0001_0000, 3'd2, 32'd0, 0));
      q.push_back(mk(1'b0, 32'h0001_0010, 3'd3, 32'd0, 1));
      q.push_back(mk(1'b0, 32'h0001_0010, 3'd2, 32'd0, 0));
      run_q(k);

      rst_abort(k);

      q.delete();
      for (int i = 0; i < 150; i++) q.push_back(rand_tx());
      run_q(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
